// File: rtl/tpg_pkg.sv
// Shared definitions for the pixel test-pattern generator.
//   tpg_mode_e   : pattern select codes carried on the 3-bit mode input
//   rgb_t        : on/off colour (one flag per channel, expanded to full scale later)
//   decode_mode  : maps a raw mode code to a pattern; unused codes fall back to bars
//   bar_colour   : colour-bar table, left to right
package tpg_pkg;

    typedef enum logic [2:0] {
        TPG_BARS  = 3'd0,
        TPG_GRID  = 3'd1,
        TPG_CHECK = 3'd2,
        TPG_CELL  = 3'd3,
        TPG_GRAD  = 3'd4,
        TPG_BOX   = 3'd5
    } tpg_mode_e;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_t;

    function automatic tpg_mode_e decode_mode(input logic [2:0] code);
        case (code)
            3'd1:    return TPG_GRID;
            3'd2:    return TPG_CHECK;
            3'd3:    return TPG_CELL;
            3'd4:    return TPG_GRAD;
            3'd5:    return TPG_BOX;
            default: return TPG_BARS;
        endcase
    endfunction

    function automatic rgb_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return rgb_t'(3'b111);   // white
            3'd1:    return rgb_t'(3'b110);   // yellow
            3'd2:    return rgb_t'(3'b011);   // cyan
            3'd3:    return rgb_t'(3'b010);   // green
            3'd4:    return rgb_t'(3'b101);   // magenta
            3'd5:    return rgb_t'(3'b100);   // red
            3'd6:    return rgb_t'(3'b001);   // blue
            default: return rgb_t'(3'b000);   // black
        endcase
    endfunction

endpackage

// File: rtl/pixel_tpg_param_if.sv
// Video bus between the timing source and the pattern generator.
//   hcount/vcount/de/hsync_in/vsync_in/mode : timing and pattern select into the generator
//   rgb_r/rgb_g/rgb_b/de_out/hsync_out/vsync_out : pixel data and delay-matched timing out
//   master : timing source / consumer side, slave : pattern generator side
interface pixel_tpg_param_if #(
    parameter int CNT_W = 10,
    parameter int R_W   = 3,
    parameter int G_W   = 3,
    parameter int B_W   = 2
);
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             de;
    logic             hsync_in;
    logic             vsync_in;
    logic [2:0]       mode;
    logic [R_W-1:0]   rgb_r;
    logic [G_W-1:0]   rgb_g;
    logic [B_W-1:0]   rgb_b;
    logic             de_out;
    logic             hsync_out;
    logic             vsync_out;

    modport master (
        output hcount, vcount, de, hsync_in, vsync_in, mode,
        input  rgb_r, rgb_g, rgb_b, de_out, hsync_out, vsync_out
    );

    modport slave (
        input  hcount, vcount, de, hsync_in, vsync_in, mode,
        output rgb_r, rgb_g, rgb_b, de_out, hsync_out, vsync_out
    );
endinterface

// File: rtl/tpg_box_motion.sv
// Bouncing-box position for the animated pattern.
//   clk_pix, reset : pixel clock, synchronous active-high reset (box to (0,0), moving +x,+y)
//   fs             : frame-start strobe; the box moves one step per frame
//   pos_x, pos_y   : top-left corner to use for the current pixel
module tpg_box_motion #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CNT_W    = 10,
    parameter int BOX_SIZE = 32,
    parameter int BOX_STEP = 2
) (
    input  logic             clk_pix,
    input  logic             reset,
    input  logic             fs,
    output logic [CNT_W-1:0] pos_x,
    output logic [CNT_W-1:0] pos_y
);
    localparam int unsigned AW = CNT_W + 1;
    localparam logic [AW-1:0] X_MAX = AW'(H_ACTIVE - BOX_SIZE);
    localparam logic [AW-1:0] Y_MAX = AW'(V_ACTIVE - BOX_SIZE);
    localparam logic [AW-1:0] STEP  = AW'(BOX_STEP);

    logic [CNT_W-1:0] bx, by;
    logic             x_neg, y_neg;
    logic [AW-1:0]    nx, ny;
    logic             x_flip, y_flip;

    // One spare bit so a step below zero shows up as MSB set rather than wrapping.
    // Touching an edge clamps and reverses in the same frame.
    always_comb begin
        nx     = '0;
        x_flip = 1'b0;
        if (!x_neg) begin
            nx     = {1'b0, bx} + STEP;
            x_flip = (nx >= X_MAX);
            if (x_flip) nx = X_MAX;
        end else begin
            nx     = {1'b0, bx} - STEP;
            x_flip = nx[AW-1] || (nx == '0);
            if (x_flip) nx = '0;
        end
    end

    always_comb begin
        ny     = '0;
        y_flip = 1'b0;
        if (!y_neg) begin
            ny     = {1'b0, by} + STEP;
            y_flip = (ny >= Y_MAX);
            if (y_flip) ny = Y_MAX;
        end else begin
            ny     = {1'b0, by} - STEP;
            y_flip = ny[AW-1] || (ny == '0);
            if (y_flip) ny = '0;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (reset) begin
            bx    <= '0;
            by    <= '0;
            x_neg <= 1'b0;
            y_neg <= 1'b0;
        end else if (fs) begin
            bx    <= nx[CNT_W-1:0];
            by    <= ny[CNT_W-1:0];
            x_neg <= x_neg ^ x_flip;
            y_neg <= y_neg ^ y_flip;
        end
    end

    // The first pixel of a frame already sees the new position, so the frame never tears.
    assign pos_x = fs ? nx[CNT_W-1:0] : bx;
    assign pos_y = fs ? ny[CNT_W-1:0] : by;
endmodule

// File: rtl/pixel_tpg_param.sv
// Parametrised test-pattern generator placed after the VGA timing generator.
//   clk_pix : pixel clock
//   reset   : synchronous, active-high
//   bus     : slave side of pixel_tpg_param_if; timing + mode in, RGB + timing out
// Two-stage pipeline: stage 1 picks a colour class, stage 2 expands it to RGB and
// blanks outside the active area. All outputs lag the inputs by two clocks.
module pixel_tpg_param
    import tpg_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CNT_W    = 10,
    parameter int R_W      = 3,
    parameter int G_W      = 3,
    parameter int B_W      = 2,
    parameter int GRID_LG2 = 5,
    parameter int CHK_LG2  = 4,
    parameter int CELL_W   = 8,
    parameter int CELL_H   = 16,
    parameter int BOX_SIZE = 32,
    parameter int BOX_STEP = 2
) (
    input  logic               clk_pix,
    input  logic               reset,
    pixel_tpg_param_if.slave   bus
);
    localparam int unsigned AW = CNT_W + 1;
    localparam logic [CNT_W-1:0] BAR_LAST  = CNT_W'(H_ACTIVE / 8 - 1);
    localparam logic [CNT_W-1:0] CELL_LX   = CNT_W'(CELL_W - 1);
    localparam logic [CNT_W-1:0] CELL_LY   = CNT_W'(CELL_H - 1);
    localparam logic [CNT_W-1:0] X_LAST    = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(V_ACTIVE - 1);
    localparam logic [AW-1:0]    BOX_EXT   = AW'(BOX_SIZE);
    localparam logic [G_W-1:0]   G_DIM     = G_W'(1 << (G_W - 1));
    localparam logic [B_W-1:0]   B_DIM     = B_W'(1 << (B_W - 1));

    logic [CNT_W-1:0] h, v;
    logic             de_q, fs, line_end;
    logic [2:0]       mode_q;
    tpg_mode_e        pat;
    logic [CNT_W-1:0] bar_cnt, cx, cy, cy_cur;
    logic [2:0]       bar_idx;
    logic [CNT_W-1:0] box_x, box_y;
    logic             in_box;

    // stage 1 decisions
    rgb_t             col;
    logic             dim_g, dim_b, grad;
    // stage 1 registers
    rgb_t             s1_col;
    logic             s1_dim_g, s1_dim_b, s1_grad, s1_de, s1_hs, s1_vs;
    logic [R_W-1:0]   s1_gr;
    logic [G_W-1:0]   s1_gg;
    // stage 2 registers
    logic [R_W-1:0]   r_q;
    logic [G_W-1:0]   g_q;
    logic [B_W-1:0]   b_q;
    logic             de_o, hs_o, vs_o;

    assign h        = bus.hcount;
    assign v        = bus.vcount;
    assign fs       = bus.de && !de_q && (v == '0);
    assign line_end = de_q && !bus.de;
    // The frame-start pixel already uses the newly selected mode and cell row 0.
    assign pat      = decode_mode(fs ? bus.mode : mode_q);
    assign cy_cur   = fs ? '0 : cy;

    tpg_box_motion #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .CNT_W    (CNT_W),
        .BOX_SIZE (BOX_SIZE),
        .BOX_STEP (BOX_STEP)
    ) u_box (
        .clk_pix (clk_pix),
        .reset   (reset),
        .fs      (fs),
        .pos_x   (box_x),
        .pos_y   (box_y)
    );

    // Bar and cell column positions come from run counters instead of dividing hcount.
    always_ff @(posedge clk_pix) begin
        if (reset) begin
            de_q    <= 1'b0;
            mode_q  <= '0;
            bar_cnt <= '0;
            bar_idx <= '0;
            cx      <= '0;
            cy      <= '0;
        end else begin
            de_q <= bus.de;
            if (fs) mode_q <= bus.mode;
            if (!bus.de) begin
                bar_cnt <= '0;
                bar_idx <= '0;
                cx      <= '0;
            end else begin
                if (bar_cnt == BAR_LAST) begin
                    bar_cnt <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_cnt <= bar_cnt + CNT_W'(1);
                end
                cx <= (cx == CELL_LX) ? '0 : cx + CNT_W'(1);
            end
            if (fs)            cy <= '0;
            else if (line_end) cy <= (cy == CELL_LY) ? '0 : cy + CNT_W'(1);
        end
    end

    assign in_box = ({1'b0, h} >= {1'b0, box_x}) && ({1'b0, h} < {1'b0, box_x} + BOX_EXT) &&
                    ({1'b0, v} >= {1'b0, box_y}) && ({1'b0, v} < {1'b0, box_y} + BOX_EXT);

    always_comb begin
        col   = '0;
        dim_g = 1'b0;
        dim_b = 1'b0;
        grad  = 1'b0;
        case (pat)
            TPG_BARS:  col = bar_colour(bar_idx);
            TPG_GRID:  if (h[GRID_LG2-1:0] == '0 || v[GRID_LG2-1:0] == '0 ||
                           h == X_LAST || v == Y_LAST) col = '1;
            TPG_CHECK: if (h[CHK_LG2] ^ v[CHK_LG2]) col = '1;
            TPG_CELL: begin
                if (cx == '0 && cy_cur == '0)      col   = rgb_t'(3'b100);
                else if (cx == '0 || cy_cur == '0) dim_g = 1'b1;
            end
            TPG_GRAD:  grad = 1'b1;
            TPG_BOX: begin
                if (in_box) col   = '1;
                else        dim_b = 1'b1;
            end
            default:   col = '0;
        endcase
    end

    always_ff @(posedge clk_pix) begin
        if (reset) begin
            s1_col   <= '0;
            s1_dim_g <= 1'b0;
            s1_dim_b <= 1'b0;
            s1_grad  <= 1'b0;
            s1_gr    <= '0;
            s1_gg    <= '0;
            s1_de    <= 1'b0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            de_o     <= 1'b0;
            hs_o     <= 1'b0;
            vs_o     <= 1'b0;
        end else begin
            s1_col   <= col;
            s1_dim_g <= dim_g;
            s1_dim_b <= dim_b;
            s1_grad  <= grad;
            s1_gr    <= h[CNT_W-1 -: R_W];
            s1_gg    <= v[CNT_W-1 -: G_W];
            s1_de    <= bus.de;
            s1_hs    <= bus.hsync_in;
            s1_vs    <= bus.vsync_in;

            de_o <= s1_de;
            hs_o <= s1_hs;
            vs_o <= s1_vs;
            if (!s1_de) begin
                r_q <= '0;
                g_q <= '0;
                b_q <= '0;
            end else if (s1_grad) begin
                r_q <= s1_gr;
                g_q <= s1_gg;
                b_q <= '0;
            end else begin
                r_q <= {R_W{s1_col.r}};
                g_q <= s1_dim_g ? G_DIM : {G_W{s1_col.g}};
                b_q <= s1_dim_b ? B_DIM : {B_W{s1_col.b}};
            end
        end
    end

    assign bus.rgb_r     = r_q;
    assign bus.rgb_g     = g_q;
    assign bus.rgb_b     = b_q;
    assign bus.de_out    = de_o;
    assign bus.hsync_out = hs_o;
    assign bus.vsync_out = vs_o;
endmodule
